fetch_unit: RTL and testbench

Instruction fetch stage of the 8-bit CPU. It owns the program counter and issues 16-bit instruction reads to instruction memory. Returned words are held in a small in-order buffer and delivered to the instruction decoder over a valid/ready handshake, together with the PC of each instruction. Execute can redirect the PC for branches and jumps, which flushes wrong-path instructions.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/inst_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, reset PC and the fetch buffer entry type for the 8-bit CPU.
package cpu_pkg;

  localparam int PC_W = 8;
  localparam int INST_W = 16;
  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop, flush and an occupancy count.
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  cpu_pkg::fetch_entry_t   push_data,
  input  logic                    pop,
  input  logic                    flush,
  output cpu_pkg::fetch_entry_t   head,
  output logic [CNT_W-1:0]        count
);
  import cpu_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A pop on an empty FIFO or a push into a full one without a pop is ignored.
  assign pop_ok  = pop && (count_q != '0);
  assign push_ok = push && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order reads, buffers returned words
// and hands them to decode with their PC; redirects flush the wrong path.
module fetch_unit #(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter int              INST_W   = cpu_pkg::INST_W,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] buf_count;
  logic [CNT_W-1:0] tag_count;
  fetch_entry_t     buf_head;
  fetch_entry_t     tag_head;
  fetch_entry_t     tag_entry;
  fetch_entry_t     buf_entry;
  logic [CNT_W:0]   credits_in_use;
  logic             pop;
  logic             issue;
  logic             accept;
  logic             tag_unused;

  assign inst_valid = (buf_count != '0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;

  // Words in flight plus buffered words, minus the one leaving this cycle, bound new issues.
  assign credits_in_use = {1'b0, outstanding_q} + {1'b0, buf_count} - (CNT_W + 1)'(pop);
  assign issue          = !redirect_valid && (credits_in_use < (CNT_W + 1)'(DEPTH));
  assign accept         = imem_rvalid && !redirect_valid && (discard_q == '0);

  assign imem_req  = rst_n && issue;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(imem_rvalid);
    discard_d     = discard_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      discard_d = outstanding_q - CNT_W'(imem_rvalid);
    end else begin
      if (issue) begin
        pc_d = pc_q + 1'b1;
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // The tag FIFO remembers the PC of every live read so responses can be labelled.
  always_comb begin
    tag_entry      = '0;
    tag_entry.pc   = pc_q;
    buf_entry.inst = imem_rdata;
    buf_entry.pc   = tag_head.pc;
  end

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (issue),
    .push_data (tag_entry),
    .pop       (accept),
    .flush     (redirect_valid),
    .head      (tag_head),
    .count     (tag_count)
  );

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_data (buf_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (buf_head),
    .count     (buf_count)
  );

  assign tag_unused = ^{tag_head.inst, tag_count};

  assign inst    = (buf_count != '0) ? buf_head.inst : '0;
  assign inst_pc = (buf_count != '0) ? buf_head.pc : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a latency-configurable memory model and
// a scoreboard of expected {inst, pc} deliveries.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  int n_pass = 0;
  int n_total = 0;
  int lat = 1;
  bit auto_ready = 0;
  fetch_entry_t exp_q[$];

  logic [3:0] pipe_v;
  logic [7:0] pipe_a [4];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Memory: mem[a] = 16'h1000 + a, answered lat cycles after the request, reset with the core.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int i = 0; i < 4; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v    <= {pipe_v[2:0], imem_req};
      pipe_a[0] <= imem_addr;
      for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end

  assign imem_rvalid = pipe_v[lat-1];
  assign imem_rdata  = 16'h1000 + {8'h00, pipe_a[lat-1]};

  task automatic push_exp(input logic [7:0] pc);
    fetch_entry_t e;
    e.pc   = pc;
    e.inst = 16'h1000 + {8'h00, pc};
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    if (auto_ready) inst_ready = (exp_q.size() != 0);
  endtask

  // Sampling point of a cycle; any accepted instruction is popped from the scoreboard.
  task automatic sample();
    fetch_entry_t e;
    @(negedge clk);
    if (rst_n && inst_valid && inst_ready) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL deliver: got pc %h inst %h, expected no delivery", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        if (inst !== e.inst || inst_pc !== e.pc)
          $display("[TB] FAIL deliver: got pc %h inst %h, expected pc %h inst %h",
                   inst_pc, inst, e.pc, e.inst);
        else n_pass++;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    auto_ready = 0;
    inst_ready = 0;
    redirect_valid = 0;
    redirect_pc = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic drain(input int budget, input string name);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      next_cycle();
      sample();
    end
    n_total++;
    if (exp_q.size() !== 0)
      $display("[TB] FAIL %s_drain: %0d instructions still pending, expected 0", name, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    inst_ready = 0;
    redirect_valid = 0;
    redirect_pc = '0;
    @(negedge clk);
    n_total++;
    if ({imem_req, inst_valid, inst, inst_pc} !== 26'h0)
      $display("[TB] FAIL reset_outputs: got req %b valid %b inst %h pc %h, expected all 0",
               imem_req, inst_valid, inst, inst_pc);
    else n_pass++;
  endtask

  task automatic test_sequential();
    lat = 1;
    do_reset();
    for (int i = 0; i < 10; i++) push_exp(8'(i));
    auto_ready = 1;
    inst_ready = 1;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) next_cycle();
      sample();
      n_total++;
      if ({imem_req, imem_addr} !== {1'b1, 8'(c - 1)})
        $display("[TB] FAIL seq_issue c%0d: got req %b addr %h, expected req 1 addr %h",
                 c, imem_req, imem_addr, 8'(c - 1));
      else n_pass++;
      n_total++;
      if (inst_valid !== (c >= 3))
        $display("[TB] FAIL seq_valid c%0d: got %b, expected %b", c, inst_valid, (c >= 3));
      else n_pass++;
    end
    drain(40, "seq");
  endtask

  task automatic test_stall();
    int reqs = 0;
    lat = 1;
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) next_cycle();
      sample();
      if (imem_req) reqs++;
      if (c >= 3) begin
        n_total++;
        if ({inst_valid, inst, inst_pc} !== {1'b1, 16'h1000, 8'h00})
          $display("[TB] FAIL stall_hold c%0d: got valid %b inst %h pc %h, expected 1 1000 00",
                   c, inst_valid, inst, inst_pc);
        else n_pass++;
      end
    end
    n_total++;
    if (reqs !== 2) $display("[TB] FAIL stall_reqs: got %0d requests, expected 2", reqs);
    else n_pass++;
    for (int i = 0; i < 8; i++) push_exp(8'(i));
    auto_ready = 1;
    drain(40, "stall");
  endtask

  task automatic test_redirect();
    int first_req = 0;
    lat = 3;
    do_reset();
    for (int i = 0; i < 4; i++) push_exp(8'h40 + 8'(i));
    auto_ready = 1;
    inst_ready = 1;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) next_cycle();
      redirect_valid = (c == 3);
      redirect_pc = 8'h40;
      sample();
      if (c == 3) begin
        n_total++;
        if ({inst_valid, imem_req} !== 2'b00)
          $display("[TB] FAIL redir_cycle: got valid %b req %b, expected 0 0", inst_valid, imem_req);
        else n_pass++;
      end
      if (c > 3 && imem_req && first_req == 0) begin
        first_req = c;
        n_total++;
        if (imem_addr !== 8'h40)
          $display("[TB] FAIL redir_addr: got %h, expected 40", imem_addr);
        else n_pass++;
      end
    end
    redirect_valid = 0;
    drain(40, "redir");
  endtask

  task automatic test_back_to_back();
    int first_valid = 0;
    lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) push_exp(8'(i));
    for (int i = 0; i < 4; i++) push_exp(8'h20 + 8'(i));
    auto_ready = 1;
    inst_ready = 1;
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) next_cycle();
      redirect_valid = (c == 6 || c == 7);
      redirect_pc = (c == 6) ? 8'h80 : 8'h20;
      sample();
      if (c == 6 || c == 7) begin
        n_total++;
        if ({inst_valid, imem_req} !== 2'b00)
          $display("[TB] FAIL b2b_cycle c%0d: got valid %b req %b, expected 0 0", c, inst_valid, imem_req);
        else n_pass++;
      end
      if (c == 8) begin
        n_total++;
        if ({imem_req, imem_addr} !== {1'b1, 8'h20})
          $display("[TB] FAIL b2b_issue: got req %b addr %h, expected 1 20", imem_req, imem_addr);
        else n_pass++;
      end
      if (c > 7 && inst_valid && first_valid == 0) first_valid = c;
    end
    redirect_valid = 0;
    n_total++;
    if (first_valid !== 10) $display("[TB] FAIL b2b_latency: got cycle %0d, expected 10", first_valid);
    else n_pass++;
    drain(40, "b2b");
  endtask

  task automatic test_wrap();
    lat = 1;
    do_reset();
    push_exp(8'hFE);
    push_exp(8'hFF);
    push_exp(8'h00);
    push_exp(8'h01);
    auto_ready = 1;
    inst_ready = 1;
    redirect_valid = 1;
    redirect_pc = 8'hFE;
    sample();
    next_cycle();
    redirect_valid = 0;
    sample();
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, 8'hFE})
      $display("[TB] FAIL wrap_issue: got req %b addr %h, expected 1 fe", imem_req, imem_addr);
    else n_pass++;
    drain(40, "wrap");
  endtask

  task automatic test_latency3();
    int out_m = 0;
    int max_out = 0;
    int pops = 0;
    lat = 3;
    do_reset();
    for (int i = 0; i < 8; i++) push_exp(8'(i));
    auto_ready = 1;
    inst_ready = 1;
    for (int c = 1; c <= 20; c++) begin
      if (c > 1) next_cycle();
      sample();
      if (inst_valid && inst_ready && c >= 5 && c <= 12) pops++;
      out_m = out_m + int'(imem_req) - int'(imem_rvalid);
      if (out_m > max_out) max_out = out_m;
    end
    n_total++;
    if (max_out !== 2) $display("[TB] FAIL lat3_outstanding: got max %0d, expected 2", max_out);
    else n_pass++;
    n_total++;
    if (pops !== 4) $display("[TB] FAIL lat3_throughput: got %0d in 8 cycles, expected 4", pops);
    else n_pass++;
    drain(40, "lat3");
  endtask

  task automatic test_async_reset();
    lat = 1;
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) next_cycle();
      sample();
    end
    n_total++;
    if (inst_valid !== 1'b1) $display("[TB] FAIL areset_pre: got valid %b, expected 1", inst_valid);
    else n_pass++;
    #2 rst_n = 0;
    #1;
    n_total++;
    if ({imem_req, inst_valid, inst, inst_pc} !== 26'h0)
      $display("[TB] FAIL areset_clear: got req %b valid %b inst %h pc %h, expected all 0",
               imem_req, inst_valid, inst, inst_pc);
    else n_pass++;
    do_reset();
    for (int i = 0; i < 3; i++) push_exp(8'(i));
    auto_ready = 1;
    inst_ready = 1;
    sample();
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, 8'h00})
      $display("[TB] FAIL areset_restart: got req %b addr %h, expected 1 00", imem_req, imem_addr);
    else n_pass++;
    drain(40, "areset");
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_latency3();
    test_async_reset();
    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
